// File: rtl/sbox_inv_pkg.sv
// Shared types, sizing and Fresh-slice bookkeeping for the masked inverse SKINNY-64 S-box.
package sbox_inv_pkg;

    localparam int unsigned SBOX_INV_NODES_PER_BIT = 15;
    localparam int unsigned SBOX_INV_N_GADGETS     = 4 * SBOX_INV_NODES_PER_BIT;
    localparam int unsigned LATENCY_DEFAULT        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] SBOX_INV_TABLE [16] = '{
        4'h3, 4'h4, 4'h6, 4'h8, 4'hc, 4'ha, 4'h1, 4'he,
        4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hb, 4'hd, 4'hf
    };

    function automatic int unsigned fresh_per_gadget(input int unsigned d);
        return (d * (d + 1)) / 2;
    endfunction

    // Node numbering inside one output bit's tree: level 0 -> 0..7, 1 -> 8..11, 2 -> 12..13, 3 -> 14.
    function automatic int unsigned level_base(input int unsigned lvl);
        return 16 - (16 >> lvl);
    endfunction

    function automatic int unsigned gadget_idx(input int unsigned bit_i, input int unsigned node);
        return bit_i * SBOX_INV_NODES_PER_BIT + node;
    endfunction

    function automatic int unsigned fresh_offset(input int unsigned gadget, input int unsigned d);
        return gadget * fresh_per_gadget(d);
    endfunction

    // Index of the random bit shared by share pair (i, j), i < j.
    function automatic int unsigned pair_idx(input int i, input int j, input int d);
        return int'(i * d - (i * (i - 1)) / 2 + (j - i - 1));
    endfunction

endpackage

// File: rtl/mux2_hpc2.sv
// d-th order HPC2 masked 2:1 mux: y = in0 ^ sel & (in0 ^ in1); output is XOR of registered terms.
module mux2_hpc2
    import sbox_inv_pkg::*;
#(
    parameter int unsigned D = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [D:0]                     sel,
    input  logic [D:0]                     in0,
    input  logic [D:0]                     in1,
    input  logic [fresh_per_gadget(D)-1:0] fresh,
    output logic [D:0]                     y_c
);

    localparam int unsigned NP = fresh_per_gadget(D);

    logic [D:0]    t_d, t_q, dly1_d, dly1_q, dly2_d, dly2_q, diag_d, diag_q;
    logic [NP-1:0] r_d, r_q, ulo_d, ulo_q, uhi_d, uhi_q, plo_d, plo_q, phi_d, phi_q;

    // Stage 1 masks the data shares with fresh bits; stage 2 gates them with the selector shares.
    always_comb begin
        t_d    = in0 ^ in1;
        dly1_d = in0;
        dly2_d = dly1_q;
        diag_d = sel & t_q;
        r_d    = fresh;
        ulo_d  = '0;
        uhi_d  = '0;
        plo_d  = '0;
        phi_d  = '0;
        y_c    = dly2_q ^ diag_q;
        for (int i = 0; i <= int'(D); i++) begin
            for (int j = i + 1; j <= int'(D); j++) begin
                ulo_d[pair_idx(i, j, int'(D))] = t_d[j] ^ fresh[pair_idx(i, j, int'(D))];
                uhi_d[pair_idx(i, j, int'(D))] = t_d[i] ^ fresh[pair_idx(i, j, int'(D))];
                plo_d[pair_idx(i, j, int'(D))] = sel[i] ? ulo_q[pair_idx(i, j, int'(D))]
                                                        : r_q[pair_idx(i, j, int'(D))];
                phi_d[pair_idx(i, j, int'(D))] = sel[j] ? uhi_q[pair_idx(i, j, int'(D))]
                                                        : r_q[pair_idx(i, j, int'(D))];
                y_c[i] = y_c[i] ^ plo_q[pair_idx(i, j, int'(D))];
                y_c[j] = y_c[j] ^ phi_q[pair_idx(i, j, int'(D))];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_q    <= '0;
            dly1_q <= '0;
            dly2_q <= '0;
            diag_q <= '0;
            r_q    <= '0;
            ulo_q  <= '0;
            uhi_q  <= '0;
            plo_q  <= '0;
            phi_q  <= '0;
        end else begin
            t_q    <= t_d;
            dly1_q <= dly1_d;
            dly2_q <= dly2_d;
            diag_q <= diag_d;
            r_q    <= r_d;
            ulo_q  <= ulo_d;
            uhi_q  <= uhi_d;
            plo_q  <= plo_d;
            phi_q  <= phi_d;
        end
    end

endmodule

// File: rtl/sbox_inv_core.sv
// Gadget network for S^-1: per output bit a 4-level BDD mux tree selected by x[0]..x[3].
module sbox_inv_core
    import sbox_inv_pkg::*;
#(
    parameter int unsigned D = 2
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [D:0][3:0]                                   x_s,
    input  logic [SBOX_INV_N_GADGETS*fresh_per_gadget(D)-1:0] fresh,
    output logic [D:0][3:0]                                   y_c
);

    localparam int unsigned FPG = fresh_per_gadget(D);

    logic [3:0][D:0] sel;
    logic [D:0]      lvl1 [4][8];
    logic [D:0]      lvl2 [4][4];
    logic [D:0]      lvl3 [4][2];
    logic [D:0]      lvl4 [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i <= int'(D); i++) begin
                sel[k][i] = x_s[i][k];
            end
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bit
        // Leaves are public truth-table bits, carried on share 0 only.
        for (genvar m = 0; m < 8; m++) begin : g_l1
            localparam logic [3:0] V0 = SBOX_INV_TABLE[2*m];
            localparam logic [3:0] V1 = SBOX_INV_TABLE[2*m+1];
            mux2_hpc2 #(.D(D)) u_mux (
                .clk   (clk),
                .rst   (rst),
                .sel   (sel[0]),
                .in0   ((D+1)'(V0[b])),
                .in1   ((D+1)'(V1[b])),
                .fresh (fresh[fresh_offset(gadget_idx(b, level_base(0) + m), D) +: FPG]),
                .y_c   (lvl1[b][m])
            );
        end
        for (genvar m = 0; m < 4; m++) begin : g_l2
            mux2_hpc2 #(.D(D)) u_mux (
                .clk   (clk),
                .rst   (rst),
                .sel   (sel[1]),
                .in0   (lvl1[b][2*m]),
                .in1   (lvl1[b][2*m+1]),
                .fresh (fresh[fresh_offset(gadget_idx(b, level_base(1) + m), D) +: FPG]),
                .y_c   (lvl2[b][m])
            );
        end
        for (genvar m = 0; m < 2; m++) begin : g_l3
            mux2_hpc2 #(.D(D)) u_mux (
                .clk   (clk),
                .rst   (rst),
                .sel   (sel[2]),
                .in0   (lvl2[b][2*m]),
                .in1   (lvl2[b][2*m+1]),
                .fresh (fresh[fresh_offset(gadget_idx(b, level_base(2) + m), D) +: FPG]),
                .y_c   (lvl3[b][m])
            );
        end
        mux2_hpc2 #(.D(D)) u_l4 (
            .clk   (clk),
            .rst   (rst),
            .sel   (sel[3]),
            .in0   (lvl3[b][0]),
            .in1   (lvl3[b][1]),
            .fresh (fresh[fresh_offset(gadget_idx(b, level_base(3)), D) +: FPG]),
            .y_c   (lvl4[b])
        );
    end

    always_comb begin
        for (int i = 0; i <= int'(D); i++) begin
            for (int b = 0; b < 4; b++) begin
                y_c[i][b] = lvl4[b][i];
            end
        end
    end

endmodule

// File: rtl/sbox_inv_hpc2_handshake.sv
// Valid/ready wrapper around the masked S^-1 core: share-hold registers, latency counter, output registers.
module sbox_inv_hpc2_handshake
    import sbox_inv_pkg::*;
#(
    parameter int unsigned SECURITY_ORDER = 2,
    parameter int unsigned LATENCY        = LATENCY_DEFAULT
) (
    input  logic                                                           clk,
    input  logic                                                           rst,
    input  logic                                                           in_valid,
    output logic                                                           in_ready,
    input  logic [SECURITY_ORDER:0][3:0]                                   X_s,
    input  logic [SBOX_INV_N_GADGETS*fresh_per_gadget(SECURITY_ORDER)-1:0] Fresh,
    output logic                                                           out_valid,
    input  logic                                                           out_ready,
    output logic [SECURITY_ORDER:0][3:0]                                   Y_s
);

    localparam int unsigned D     = SECURITY_ORDER;
    localparam int unsigned CNT_W = $clog2(LATENCY);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [D:0][3:0]  hold_q, hold_d, y_q, y_d, core_y_c;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    sbox_inv_core #(.D(D)) u_core (
        .clk   (clk),
        .rst   (rst),
        .x_s   (hold_q),
        .fresh (Fresh),
        .y_c   (core_y_c)
    );

    // Y is captured only on the BUSY->DONE step so no transient core value reaches the outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        y_d         = y_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    hold_d     = X_s;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    y_d         = core_y_c;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    hold_d      = '0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                hold_d      = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            y_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            y_q         <= y_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Y_s       = y_q;

endmodule

// File: tb/tb_sbox_inv_hpc2_handshake.sv
// Scoreboard bench for sbox_inv_hpc2_handshake: random share splits and Fresh, table reference model.
module tb_sbox_inv_hpc2_handshake;
    import sbox_inv_pkg::*;

    localparam int unsigned D   = 2;
    localparam int unsigned LAT = 8;
    localparam int unsigned FW  = SBOX_INV_N_GADGETS * fresh_per_gadget(D);
    localparam logic [3:0] SINV [16] = '{
        4'h3, 4'h4, 4'h6, 4'h8, 4'hc, 4'ha, 4'h1, 4'he,
        4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hb, 4'hd, 4'hf
    };

    typedef logic [D:0][3:0] shares_t;
    typedef struct {
        logic [3:0]  y;
        int unsigned cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    shares_t       X_s, Y_s;
    logic [FW-1:0] Fresh;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    exp_t        sb[$];

    sbox_inv_hpc2_handshake #(.SECURITY_ORDER(D), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X_s       (X_s),
        .Fresh     (Fresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y_s       (Y_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic shares_t split(input logic [3:0] x);
        shares_t    s;
        logic [3:0] acc;
        acc = x;
        for (int i = 0; i < int'(D); i++) begin
            s[i] = 4'($urandom);
            acc  = acc ^ s[i];
        end
        s[D] = acc;
        return s;
    endfunction

    function automatic logic [3:0] unmask(input shares_t s);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i <= int'(D); i++) r = r ^ s[i];
        return r;
    endfunction

    // New randomness every cycle.
    initial begin
        Fresh = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < int'(FW); k++) Fresh[k] = 1'($urandom);
        end
    end

    // Monitor: on each rising out_valid, pop the oldest expectation and compare value and latency.
    initial begin
        logic prev_ov;
        exp_t e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(unmask(Y_s)), 32'hffff_ffff);
                end else begin
                    e = sb.pop_front();
                    check("result", 32'(unmask(Y_s)), 32'(e.y));
                    check("latency", cyc - e.cyc, LAT + 1);
                end
            end
            prev_ov = out_valid;
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] x, input bit keep, output int unsigned acc);
        int unsigned waited;
        waited   = 0;
        X_s      = split(x);
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        acc = cyc;
        if (in_ready !== 1'b1) begin
            check("accept_timeout", 32'(waited), 32'd0);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{y: SINV[x], cyc: cyc});
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned waited;
        waited = 0;
        while ((sb.size() != 0 || out_valid === 1'b1) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0 || out_valid === 1'b1) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int unsigned acc, prev_acc, waited;
        shares_t     snap;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; X_s = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(Y_s), 32'd0);
        check("rst_hold", 32'(dut.hold_q), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Exhaustive over X.
        out_ready = 1'b1;
        for (int x = 0; x < 16; x++) send(4'(x), 1'b0, acc);
        drain();

        // Same X, many share splits and Fresh values.
        for (int n = 0; n < 100; n++) send(4'h5, 1'b0, acc);
        drain();

        // Back-to-back stream with in_valid held high.
        prev_acc = 0;
        for (int n = 0; n < 16; n++) begin
            send(4'($urandom), 1'b1, acc);
            if (n > 0) check("stream_gap", acc - prev_acc, LAT + 2);
            prev_acc = acc;
        end
        in_valid = 1'b0;
        drain();

        // Backpressure in DONE with a competing in_valid.
        out_ready = 1'b0;
        send(4'h7, 1'b0, acc);
        waited = 0;
        while (out_valid !== 1'b1 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check("bp_reach_done", 32'(out_valid), 32'd1);
        snap     = Y_s;
        X_s      = split(4'h3);
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_shares", 32'(Y_s), 32'(snap));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        check("bp_value", 32'(unmask(Y_s)), 32'he);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("zeroised_hold", 32'(dut.hold_q), 32'd0);

        // X toggling while idle must not disturb the outputs.
        for (int n = 0; n < 5; n++) begin
            X_s = split(4'($urandom));
            @(negedge clk);
            check("idle_shares", 32'(Y_s), 32'(snap));
            check("idle_value", 32'(unmask(Y_s)), 32'he);
        end
        check("idle_no_output", 32'(out_valid), 32'd0);

        // Reset in the middle of BUSY.
        send(4'hb, 1'b0, acc);
        repeat (4) @(negedge clk);
        check("mid_cnt", 32'(dut.cnt_q), 32'd4);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_y", 32'(Y_s), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_hold", 32'(dut.hold_q), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        send(4'h9, 1'b0, acc);
        drain();
        check("post_rst_y", 32'(unmask(Y_s)), 32'h2);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
